axi_dma_ctrl: RTL

- Single-channel DMA copy engine. Moves LEN consecutive words from a source address to a destination address.
- Acts as the AXI-lite-style master in front of the subsystem's single-port AXI memory.
- Uses its own read channel and write channel, one word at a time: read, then write.
- Configured by a start pulse. Reports completion with a one-cycle done pulse.

---
 rtl/axi_dma_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/axi_dma_ctrl.sv
// Single-channel DMA copy engine: reads one word from the source, writes it to
// the destination, and repeats until the programmed word count is exhausted.
module axi_dma_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [LEN_WIDTH-1:0]    len,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    words_done,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [2:0]              state_dbg
);
    // Valid/ready: a transfer happens on a rising edge where both valid and ready
    // are high; a valid, once raised, holds its payload until that edge.

    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

    typedef enum logic [2:0] {IDLE, RD, WR, WR_RESP, DONE} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 ar_done, r_done, aw_done, w_done, b_done;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic ar_seen, r_seen, aw_seen, w_seen, b_seen;
    logic word_end, last_word;

    assign ar_hs = arvalid & arready;
    // Only the first read beat of a word is captured into the buffer.
    assign r_hs  = rready & rvalid & ~r_done;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bready & bvalid;

    assign ar_seen = ar_done | ar_hs;
    assign r_seen  = r_done  | r_hs;
    assign aw_seen = aw_done | aw_hs;
    assign w_seen  = w_done  | w_hs;
    assign b_seen  = b_done  | b_hs;

    assign word_end  = ((state == WR) && aw_seen && w_seen && b_seen) ||
                       ((state == WR_RESP) && b_hs);
    assign last_word = (remaining == LEN_WIDTH'(1));

    assign wstrb     = '1;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            words_done <= '0;
            remaining  <= '0;
            araddr     <= '0;
            awaddr     <= '0;
            wdata      <= '0;
            ar_done    <= 1'b0;
            r_done     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            b_done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        araddr     <= src_addr & ALIGN_MASK;
                        awaddr     <= dst_addr & ALIGN_MASK;
                        remaining  <= len;
                        words_done <= '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RD;
                            busy    <= 1'b1;
                            arvalid <= 1'b1;
                            rready  <= 1'b1;
                            ar_done <= 1'b0;
                            r_done  <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        ar_done <= 1'b1;
                    end
                    if (r_hs) begin
                        wdata  <= rdata;
                        r_done <= 1'b1;
                    end
                    if (ar_seen && r_seen) begin
                        state   <= WR;
                        rready  <= 1'b0;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        bready  <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        b_done  <= 1'b0;
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (b_hs) begin
                        b_done <= 1'b1;
                    end
                    if (aw_seen && w_seen && !b_seen) begin
                        state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    // Completion is handled by the word_end path below.
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Word completion overrides the per-state next-state choice above.
            if (word_end) begin
                araddr     <= araddr + ADDR_STEP;
                awaddr     <= awaddr + ADDR_STEP;
                words_done <= words_done + LEN_WIDTH'(1);
                remaining  <= remaining - LEN_WIDTH'(1);
                bready     <= 1'b0;
                if (last_word) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state   <= RD;
                    arvalid <= 1'b1;
                    rready  <= 1'b1;
                    ar_done <= 1'b0;
                    r_done  <= 1'b0;
                end
            end
        end
    end
endmodule
